// File: rtl/vmem_blitter.sv
// Block copy/fill engine driving port b of the extension video RAM.
// Copy takes three cycles per byte (read, wait, write); fill writes one byte per cycle.
module vmem_blitter #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [DATA_WIDTH-1:0] fill_val,
  input  logic                  hold,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FILL = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;
  logic                  dir_q, dir_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

  // Address stepping wraps naturally at the register width in both directions.
  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic down);
    return down ? (a - ADDR_ONE) : (a + ADDR_ONE);
  endfunction

  always_comb begin
    case (state_q)
      S_RD, S_WAIT: mem_addr = src_q;
      S_WR, S_FILL: mem_addr = dst_q;
      default:      mem_addr = last_addr_q;
    endcase
  end

  assign mem_din = (state_q == S_FILL) ? fill_q : data_q;
  assign mem_we  = ((state_q == S_WR) || (state_q == S_FILL)) && !hold;
  assign busy    = (state_q == S_RD) || (state_q == S_WAIT) ||
                   (state_q == S_WR) || (state_q == S_FILL);
  assign done    = (state_q == S_FIN);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    count_d     = count_q;
    data_d      = data_q;
    fill_d      = fill_q;
    dir_d       = dir_q;
    last_addr_d = mem_addr;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          count_d = len;
          fill_d  = fill_val;
          dir_d   = dir;
          if (len == '0) state_d = S_FIN;
          else           state_d = mode ? S_FILL : S_RD;
        end
      end
      S_RD: begin
        if (!hold) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Read data from the address presented in RD is valid now.
        data_d  = mem_dout;
        state_d = S_WR;
      end
      S_WR: begin
        if (!hold) begin
          src_d   = step_addr(src_q, dir_q);
          dst_d   = step_addr(dst_q, dir_q);
          count_d = count_q - LEN_ONE;
          state_d = (count_q == LEN_ONE) ? S_FIN : S_RD;
        end
      end
      S_FILL: begin
        if (!hold) begin
          dst_d   = step_addr(dst_q, dir_q);
          count_d = count_q - LEN_ONE;
          if (count_q == LEN_ONE) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      count_q     <= '0;
      data_q      <= '0;
      fill_q      <= '0;
      dir_q       <= 1'b0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      count_q     <= count_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      dir_q       <= dir_d;
      last_addr_q <= last_addr_d;
    end
  end

endmodule

// File: tb/tb_vmem_blitter.sv
// Bench for vmem_blitter: a reference memory model predicts every port-b write,
// and a negedge compare process checks each write, done pulse and hold behaviour.
module tb_vmem_blitter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, mode, dir, hold;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] len;
  logic [DW-1:0] fill_val;
  logic          busy, done, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  vmem_blitter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .dir(dir),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .hold(hold), .busy(busy), .done(done), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural RAM with one-cycle registered read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  wr_t exp_q[$];
  int  exp_rd = 0;

  int checks = 0;
  int fails  = 0;
  int wr_total = 0, done_total = 0, busy_total = 0;
  int last_wr_cyc = 0, done_cyc = 0;
  int wr_cyc_q[$];

  int base_w, base_q, base_b, base_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_rd = exp_q.size();
    end else begin
      if (busy) busy_total++;
      if (hold) chk("we_during_hold", {31'd0, mem_we}, 32'd0);
      if (mem_we) begin
        wr_total++;
        wr_cyc_q.push_back(cyc);
        last_wr_cyc = cyc;
        if (exp_rd >= exp_q.size()) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                   mem_addr, mem_din, cyc);
        end else begin
          chk("wr_addr", {17'd0, mem_addr}, {17'd0, exp_q[exp_rd].a});
          chk("wr_data", {24'd0, mem_din}, {24'd0, exp_q[exp_rd].d});
          exp_rd++;
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
        chk("writes_outstanding_at_done", exp_q.size() - exp_rd, 32'd0);
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base_w = wr_total;
    base_q = wr_cyc_q.size();
    base_b = busy_total;
    base_d = done_total;
  endtask

  // Predict the write sequence with plain modular arithmetic, then pulse start.
  task automatic issue(input bit m, input bit d, input logic [AW-1:0] s,
                       input logic [AW-1:0] t, input int n, input logic [DW-1:0] f,
                       output int sc);
    for (int i = 0; i < n; i++) begin
      int sa, da;
      logic [DW-1:0] v;
      sa = (int'(s) + (d ? -i : i)) & 32'h7FFF;
      da = (int'(t) + (d ? -i : i)) & 32'h7FFF;
      v  = m ? f : ref_mem[sa];
      ref_mem[da] = v;
      exp_q.push_back('{a: da[AW-1:0], d: v});
    end
    mode = m; dir = d; src_addr = s; dst_addr = t; len = LW'(n); fill_val = f;
    start = 1'b1;
    sc = cyc;
    drive_edge();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    for (int k = 0; k < budget && done_total == base_d; k++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (done_total == base_d) begin
      fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic report(input string nm);
    $display("xact %-12s writes=%0d busy_cycles=%0d done_pulses=%0d", nm,
             wr_total - base_w, busy_total - base_b, done_total - base_d);
  endtask

  int sc;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; dir = 1'b0; hold = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; fill_val = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_we", {31'd0, mem_we}, 32'd0);
    chk("reset_addr", {17'd0, mem_addr}, 32'd0);
    chk("reset_din", {24'd0, mem_din}, 32'd0);
    rst = 1'b0;
    drive_edge();

    // Fill 4 bytes of 0xA5 at 0x0100.
    snap();
    issue(1, 0, 15'h0000, 15'h0100, 4, 8'hA5, sc);
    wait_done("fill", 50);
    drive_edge(); drive_edge();
    chk("fill_writes", wr_total - base_w, 4);
    chk("fill_first_write", wr_cyc_q[base_q], sc + 1);
    for (int i = 1; i < 4; i++)
      chk("fill_gap", wr_cyc_q[base_q+i] - wr_cyc_q[base_q+i-1], 1);
    chk("fill_done_after_last", done_cyc, last_wr_cyc + 1);
    chk("fill_busy_span", busy_total - base_b + 1, 5);
    chk("fill_done_once", done_total - base_d, 1);
    for (int i = 0; i < 4; i++) chk("fill_ram", {24'd0, ram[15'h0100 + 15'(i)]}, 32'hA5);
    report("fill");

    // Ascending copy 0x0000..2 -> 0x0200..2.
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33;
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h22; ref_mem[2] = 8'h33;
    snap();
    issue(0, 0, 15'h0000, 15'h0200, 3, 8'h00, sc);
    wait_done("copy_asc", 50);
    drive_edge();
    chk("copy_writes", wr_total - base_w, 3);
    chk("copy_first_write", wr_cyc_q[base_q], sc + 3);
    chk("copy_gap1", wr_cyc_q[base_q+1] - wr_cyc_q[base_q], 3);
    chk("copy_gap2", wr_cyc_q[base_q+2] - wr_cyc_q[base_q+1], 3);
    chk("copy_done_after_last", done_cyc, last_wr_cyc + 1);
    chk("copy_busy_span", busy_total - base_b + 1, 10);
    chk("copy_ram0", {24'd0, ram[15'h0200]}, 32'h11);
    chk("copy_ram1", {24'd0, ram[15'h0201]}, 32'h22);
    chk("copy_ram2", {24'd0, ram[15'h0202]}, 32'h33);
    report("copy_asc");

    // Descending copy crossing the 0x0000/0x7FFF boundary.
    ram[15'h7FFC] = 8'h44; ram[15'h7FFD] = 8'h55; ram[15'h7FFE] = 8'h66;
    ref_mem[15'h7FFC] = 8'h44; ref_mem[15'h7FFD] = 8'h55; ref_mem[15'h7FFE] = 8'h66;
    snap();
    issue(0, 1, 15'h7FFE, 15'h0001, 3, 8'h00, sc);
    wait_done("copy_desc", 50);
    drive_edge();
    chk("desc_writes", wr_total - base_w, 3);
    chk("desc_ram_0001", {24'd0, ram[15'h0001]}, 32'h66);
    chk("desc_ram_0000", {24'd0, ram[15'h0000]}, 32'h55);
    chk("desc_ram_7fff", {24'd0, ram[15'h7FFF]}, 32'h44);
    report("copy_desc");

    // Fill of 3 with two held cycles in the middle.
    snap();
    issue(1, 0, 15'h0000, 15'h0300, 3, 8'h3C, sc);
    drive_edge(); hold = 1'b1;
    drive_edge();
    drive_edge(); hold = 1'b0;
    wait_done("fill_hold", 50);
    drive_edge();
    chk("hold_writes", wr_total - base_w, 3);
    chk("hold_busy_span", busy_total - base_b + 1, 6);
    for (int i = 0; i < 3; i++) chk("hold_ram", {24'd0, ram[15'h0300 + 15'(i)]}, 32'h3C);
    report("fill_hold");

    // Copy of one byte with hold in RD, WAIT and WR.
    snap();
    issue(0, 0, 15'h0201, 15'h0400, 1, 8'h00, sc);
    hold = 1'b1;
    drive_edge(); hold = 1'b0;
    drive_edge(); hold = 1'b1;
    drive_edge();
    drive_edge(); hold = 1'b0;
    wait_done("copy_hold", 50);
    drive_edge();
    chk("chold_writes", wr_total - base_w, 1);
    chk("chold_write_cycle", wr_cyc_q[base_q], sc + 5);
    chk("chold_ram", {24'd0, ram[15'h0400]}, 32'h22);
    report("copy_hold");

    // len=0 is a no-op that still pulses done.
    snap();
    issue(1, 0, 15'h0000, 15'h0500, 0, 8'h99, sc);
    wait_done("len0", 10);
    drive_edge();
    chk("len0_done_cycle", done_cyc, sc + 1);
    chk("len0_writes", wr_total - base_w, 0);
    report("len0");

    // Starts while busy and in the FIN cycle are both ignored.
    snap();
    issue(1, 0, 15'h0000, 15'h0500, 5, 8'h77, sc);
    drive_edge();
    start = 1'b1; mode = 1'b1; dst_addr = 15'h0600; len = 16'd2; fill_val = 8'h11;
    drive_edge(); start = 1'b0;
    drive_edge();
    drive_edge();
    drive_edge();
    start = 1'b1; dst_addr = 15'h0700; len = 16'd1; fill_val = 8'h22;
    drive_edge(); start = 1'b0;
    repeat (6) drive_edge();
    chk("ign_writes", wr_total - base_w, 5);
    chk("ign_done_once", done_total - base_d, 1);
    chk("ign_done_cycle", done_cyc, sc + 6);
    chk("ign_busy_idle", {31'd0, busy}, 32'd0);
    chk("ign_ram_0600", {24'd0, ram[15'h0600]}, 32'h00);
    chk("ign_ram_0700", {24'd0, ram[15'h0700]}, 32'h00);
    chk("ign_ram_0504", {24'd0, ram[15'h0504]}, 32'h77);
    report("ignored_start");

    // Asynchronous reset in the WR cycle of the third byte of a 4-byte copy.
    snap();
    issue(0, 0, 15'h0000, 15'h0800, 4, 8'h00, sc);
    for (int k = 0; k < 40 && (wr_total - base_w) < 2; k++) begin
      @(negedge clk);
      #1;
    end
    chk("rst_two_written", wr_total - base_w, 2);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_we_before", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_busy_drop", {31'd0, busy}, 32'd0);
    chk("rst_we_drop", {31'd0, mem_we}, 32'd0);
    chk("rst_done_low", {31'd0, done}, 32'd0);
    chk("rst_addr_clear", {17'd0, mem_addr}, 32'd0);
    drive_edge(); rst = 1'b0;
    repeat (10) drive_edge();
    chk("rst_writes_total", wr_total - base_w, 2);
    chk("rst_no_done", done_total - base_d, 0);
    chk("rst_ram_0800", {24'd0, ram[15'h0800]}, 32'h55);
    chk("rst_ram_0801", {24'd0, ram[15'h0801]}, 32'h66);
    chk("rst_ram_0802", {24'd0, ram[15'h0802]}, 32'h00);
    report("reset_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
